// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle issue/writeback controller for the regfile/ALU pair
//
// Purpose:
//   Accepts one MIPS instruction per valid/ready handshake, decodes addu, subu,
//   ori and lui, reads the operands from the register file, drives the
//   combinational ALU and writes the result back. One instruction is in flight
//   at a time: IDLE -> DECODE -> EXEC -> WB -> IDLE (DECODE -> IDLE on illegal).
//   Accept in cycle N gives rf_we in cycle N+3; throughput is 1 per 4 cycles.
//
// Optional feature macro: ALU_ZERO_FLAG_EN
//   defined   : zero_flag captures alu_zero for each retiring instruction.
//   undefined : zero_flag is tied to 0 and alu_zero is ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_valid/instr     instruction offer (word held until accepted)
//   instr_ready           high only in IDLE
//   rs_addr/rt_addr       regfile read addresses from the latched instruction
//   rs_data/rt_data       regfile read data (same cycle)
//   busA/busB/ALUctr      registered ALU operands and opcode
//   alu_out/alu_zero      ALU result and zero flag
//   rf_we/rf_waddr/rf_wdata  writeback strobe (one-cycle pulse), address, data
//   illegal               one-cycle pulse when an unsupported word is dropped
//   retired               completed-instruction counter (wraps)
//   zero_flag             zero flag of the last retired instruction (optional)

module alu_issue_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [31:0]       busA,
  output logic [31:0]       busB,
  output logic [2:0]        ALUctr,
  input  logic [31:0]       alu_out,
  input  logic              alu_zero,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired,
  output logic              zero_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [2:0] CTR_ADDU   = 3'b000;
  localparam logic [2:0] CTR_SUBU   = 3'b001;
  localparam logic [2:0] CTR_LUI    = 3'b011;
  localparam logic [2:0] CTR_ORI    = 3'b100;

  state_t              state_q;
  logic [31:0]         instr_q;
  logic [31:0]         busa_q;
  logic [31:0]         busb_q;
  logic [2:0]          ctr_q;
  logic [REG_AW-1:0]   dest_q;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_waddr_q;
  logic [31:0]         rf_wdata_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    retired_q;
  logic                zero_q;

  // Decode of the latched word, consumed in DECODE.
  logic                legal_d;
  logic [31:0]         busa_d;
  logic [31:0]         busb_d;
  logic [2:0]          ctr_d;
  logic [REG_AW-1:0]   dest_d;

  function automatic logic is_legal(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    if (w[31:26] == OP_RTYPE && (w[5:0] == FN_ADDU || w[5:0] == FN_SUBU)) ok = 1'b1;
    if (w[31:26] == OP_ORI || w[31:26] == OP_LUI) ok = 1'b1;
    return ok;
  endfunction

  assign rs_addr = REG_AW'(instr_q[25:21]);
  assign rt_addr = REG_AW'(instr_q[20:16]);

  always_comb begin
    legal_d = is_legal(instr_q);
    busa_d  = rs_data;
    busb_d  = rt_data;
    ctr_d   = CTR_ADDU;
    dest_d  = REG_AW'(instr_q[15:11]);
    if (instr_q[31:26] == OP_RTYPE) begin
      if (instr_q[5:0] == FN_SUBU) ctr_d = CTR_SUBU;
    end else if (instr_q[31:26] == OP_ORI) begin
      busb_d = {16'b0, instr_q[15:0]};
      ctr_d  = CTR_ORI;
      dest_d = REG_AW'(instr_q[20:16]);
    end else begin
      // lui: the ALU does the shift, so operand A is forced to zero.
      busa_d = 32'b0;
      busb_d = {16'b0, instr_q[15:0]};
      ctr_d  = CTR_LUI;
      dest_d = REG_AW'(instr_q[20:16]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      busa_q     <= '0;
      busb_q     <= '0;
      ctr_q      <= CTR_ADDU;
      dest_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
      zero_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q   <= instr;
            // Flagged at accept so the pulse lands in the DECODE cycle.
            illegal_q <= !is_legal(instr);
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal_d) begin
            state_q <= S_IDLE;
          end else begin
            busa_q  <= busa_d;
            busb_q  <= busb_d;
            ctr_q   <= ctr_d;
            dest_q  <= dest_d;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Writeback registers load here so the strobe is visible during WB.
          rf_wdata_q <= alu_out;
          rf_waddr_q <= dest_q;
          rf_we_q    <= (dest_q != '0);
          retired_q  <= retired_q + CNT_W'(1);
`ifdef ALU_ZERO_FLAG_EN
          zero_q     <= alu_zero;
`endif
          state_q    <= S_WB;
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busA        = busa_q;
  assign busB        = busb_q;
  assign ALUctr      = ctr_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

`ifdef ALU_ZERO_FLAG_EN
  assign zero_flag = zero_q;
  logic unused_bits;
  assign unused_bits = ^instr_q[10:6];
`else
  assign zero_flag = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{instr_q[10:6], alu_zero, zero_q};
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with regfile and ALU models

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] busA, busB;
  logic [2:0]  ALUctr;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        illegal;
  logic [15:0] retired;
  logic        zero_flag;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .busA(busA), .busB(busB), .ALUctr(ALUctr),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .illegal(illegal), .retired(retired), .zero_flag(zero_flag)
  );

  // Environment: static register file and combinational ALU.
  logic [31:0] regs [32];
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  always_comb begin
    case (ALUctr)
      3'b000:  alu_out = busA + busB;
      3'b001:  alu_out = busA - busB;
      3'b100:  alu_out = busA | busB;
      3'b011:  alu_out = {busB[15:0], 16'b0};
      default: alu_out = 32'b0;
    endcase
    alu_zero = (alu_out == 32'b0);
  end

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wb_t;

  wb_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_ret = 0;
  logic exp_zero = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Writeback monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_addr", {27'b0, rf_waddr}, {27'b0, e.addr});
        check("wb_data", rf_wdata, e.data);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic retire_model(input logic [31:0] data);
    exp_ret = (exp_ret + 1) & 32'hFFFF;
`ifdef ALU_ZERO_FLAG_EN
    exp_zero = (data == 32'b0);
`else
    exp_zero = 1'b0;
`endif
  endtask

  task automatic issue(input logic [31:0] w, input bit ill, input logic [2:0] ctr,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic [31:0] data);
    check("ready_idle", {31'b0, instr_ready}, 32'd1);
    instr = w;
    instr_valid = 1'b1;
    if (!ill && dest != 5'd0) sb.push_back('{dest, data, cyc + 3});
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    check("illegal_n1", {31'b0, illegal}, {31'b0, ill});
    check("ready_n1", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    if (ill) begin
      check("illegal_n2", {31'b0, illegal}, 32'd0);
      check("ready_n2", {31'b0, instr_ready}, 32'd1);
      check("retired_ill", {16'b0, retired}, exp_ret);
      check("zero_hold", {31'b0, zero_flag}, {31'b0, exp_zero});
    end else begin
      check("rs_addr", {27'b0, rs_addr}, {27'b0, w[25:21]});
      check("busA", busA, a);
      check("busB", busB, b);
      check("ALUctr", {29'b0, ALUctr}, {29'b0, ctr});
      check("we_n2", {31'b0, rf_we}, 32'd0);
      @(posedge clk); #1;
      retire_model(data);
      check("we_n3", {31'b0, rf_we}, {31'b0, dest != 5'd0});
      check("retired", {16'b0, retired}, exp_ret);
      check("zero_flag", {31'b0, zero_flag}, {31'b0, exp_zero});
      @(posedge clk); #1;
      check("ready_n4", {31'b0, instr_ready}, 32'd1);
      check("we_n4", {31'b0, rf_we}, 32'd0);
    end
    check("sb_drain", sb.size(), 32'd0);
  endtask

  localparam logic [31:0] W_ADDU = 32'h00221821;  // addu $3,$1,$2
  localparam logic [31:0] W_SUBU = 32'h00A52023;  // subu $4,$5,$5
  localparam logic [31:0] W_ORI  = 32'h34C78001;  // ori  $7,$6,0x8001
  localparam logic [31:0] W_LUI0 = 32'h3C00ABCD;  // lui  $0,0xABCD
  localparam logic [31:0] W_LUI9 = 32'h3C091234;  // lui  $9,0x1234
  localparam logic [31:0] W_LW   = 32'h8C000000;  // lw (unsupported)
  localparam logic [31:0] W_ADD  = 32'h00221820;  // add (unsupported funct)

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
    regs[1] = 32'hFFFFFFFF;
    regs[2] = 32'h00000002;
    regs[5] = 32'h00001234;
    regs[6] = 32'h00010000;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 32'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_busA", busA, 32'd0);
    check("rst_busB", busB, 32'd0);
    check("rst_ALUctr", {29'b0, ALUctr}, 32'd0);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_retired", {16'b0, retired}, 32'd0);
    check("rst_zero", {31'b0, zero_flag}, 32'd0);
    check("rst_rs_addr", {27'b0, rs_addr}, 32'd0);

    issue(W_ADDU, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h2, 5'd3, 32'h00000001);
    issue(W_SUBU, 1'b0, 3'b001, 32'h1234, 32'h1234, 5'd4, 32'h00000000);
    issue(W_LW,   1'b1, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    issue(W_ORI,  1'b0, 3'b100, 32'h00010000, 32'h00008001, 5'd7, 32'h00018001);
    issue(W_LUI0, 1'b0, 3'b011, 32'h0, 32'h0000ABCD, 5'd0, 32'hABCD0000);
    issue(W_ADD,  1'b1, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    issue(W_LUI9, 1'b0, 3'b011, 32'h0, 32'h00001234, 5'd9, 32'h12340000);

    // Reset during EXEC drops the instruction: no strobe, counter cleared.
    instr = W_ADDU;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ret = 0;
    exp_zero = 1'b0;
    check("rstx_ready", {31'b0, instr_ready}, 32'd1);
    check("rstx_retired", {16'b0, retired}, 32'd0);
    check("rstx_we", {31'b0, rf_we}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("rstx_retired_late", {16'b0, retired}, 32'd0);

    // Valid held high: one accept every fourth cycle.
    begin
      int accepts = 0;
      int last_cyc = -1;
      instr = W_ADDU;
      instr_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (instr_ready) begin
          sb.push_back('{5'd3, 32'h00000001, cyc + 3});
          if (last_cyc >= 0) check("b2b_gap", cyc - last_cyc, 32'd4);
          last_cyc = cyc;
          accepts++;
          retire_model(32'h1);
        end
        @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      check("b2b_accepts", accepts, 32'd3);
      repeat (4) @(posedge clk);
      #1;
      check("b2b_retired", {16'b0, retired}, exp_ret);
      check("b2b_zero", {31'b0, zero_flag}, {31'b0, exp_zero});
      check("b2b_sb_empty", sb.size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
